// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : div_arbiter
//  Purpose  : Shares one serial divider between two requester ports. A
//             round-robin grant picks a pending request, latches its
//             operands, issues it to the divider and routes the result back
//             to the owning port. A per-port flush kills the owner's
//             in-flight operation and aborts the divider when needed.
//             The divider is expected to use STABLE_HANDSHAKE=1 and to share
//             rst_i with this block.
//  Options  : DIV_ARB_RESULT_CACHE_EN - single-entry result cache; a grant
//             whose operands and opcode hit the entry is answered directly.
//  Revision : 1.0 - initial release
// ============================================================================
module div_arbiter #(
    parameter int WIDTH    = 64,
    parameter int ID_W     = 4,
    parameter int NR_PORTS = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NR_PORTS-1:0]            req_vld_i,
    output logic [NR_PORTS-1:0]            req_rdy_o,
    input  logic [NR_PORTS-1:0][WIDTH-1:0] req_op_a_i,
    input  logic [NR_PORTS-1:0][WIDTH-1:0] req_op_b_i,
    input  logic [NR_PORTS-1:0][1:0]       req_opcode_i,
    input  logic [NR_PORTS-1:0][ID_W-1:0]  req_id_i,
    input  logic [NR_PORTS-1:0]            flush_i,
    output logic [NR_PORTS-1:0]            resp_vld_o,
    input  logic [NR_PORTS-1:0]            resp_rdy_i,
    output logic [ID_W-1:0]                resp_id_o,
    output logic [WIDTH-1:0]               resp_res_o,
    output logic [WIDTH-1:0]               div_op_a_o,
    output logic [WIDTH-1:0]               div_op_b_o,
    output logic [1:0]                     div_opcode_o,
    output logic [ID_W-1:0]                div_id_o,
    output logic                           div_in_vld_o,
    input  logic                           div_in_rdy_i,
    output logic                           div_flush_o,
    input  logic                           div_out_vld_i,
    output logic                           div_out_rdy_o,
    input  logic [ID_W-1:0]                div_id_i,
    input  logic [WIDTH-1:0]               div_res_i
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_issue = 3'd1;
    localparam logic [2:0] c_st_busy  = 3'd2;
    localparam logic [2:0] c_st_kill  = 3'd3;
    localparam logic [2:0] c_st_resp  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             r_rr_ptr;
    logic             r_owner;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [1:0]       r_opcode;
    logic [ID_W-1:0]  r_id;
    logic [ID_W-1:0]  r_resp_id;
    logic [WIDTH-1:0] r_resp_res;

    logic [1:0]       w_eligible;
    logic             w_winner;
    logic             w_owner_flush;
    logic             w_grant;
    logic             w_capture;
    logic             w_rr_update;
    logic             w_cache_hit;

    assign w_eligible    = req_vld_i & ~flush_i;
    // With both ports eligible the pointer decides; otherwise take whichever is.
    assign w_winner      = (&w_eligible) ? r_rr_ptr : w_eligible[1];
    assign w_owner_flush = flush_i[r_owner];

    assign div_op_a_o    = r_op_a;
    assign div_op_b_o    = r_op_b;
    assign div_opcode_o  = r_opcode;
    assign div_id_o      = r_id;
    assign resp_id_o     = r_resp_id;
    assign resp_res_o    = r_resp_res;

`ifdef DIV_ARB_RESULT_CACHE_EN
    logic             r_cache_vld;
    logic [WIDTH-1:0] r_cache_a;
    logic [WIDTH-1:0] r_cache_b;
    logic [1:0]       r_cache_opcode;
    logic [WIDTH-1:0] r_cache_res;

    assign w_cache_hit = r_cache_vld
                       && (r_cache_a == req_op_a_i[w_winner])
                       && (r_cache_b == req_op_b_i[w_winner])
                       && (r_cache_opcode == req_opcode_i[w_winner]);

    // Remember the last delivered divider result together with its inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cache_vld    <= 1'b0;
            r_cache_a      <= '0;
            r_cache_b      <= '0;
            r_cache_opcode <= '0;
            r_cache_res    <= '0;
        end else if (w_capture) begin
            r_cache_vld    <= 1'b1;
            r_cache_a      <= r_op_a;
            r_cache_b      <= r_op_b;
            r_cache_opcode <= r_opcode;
            r_cache_res    <= div_res_i;
        end
    end
`else
    assign w_cache_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        req_rdy_o     = '0;
        resp_vld_o    = '0;
        div_in_vld_o  = 1'b0;
        div_flush_o   = 1'b0;
        div_out_rdy_o = 1'b0;
        w_grant       = 1'b0;
        w_capture     = 1'b0;
        w_rr_update   = 1'b0;
        case (r_state)
            c_st_idle: begin
                // No grant while reset is held so nothing is accepted and lost.
                if (!rst_i && (|w_eligible)) begin
                    req_rdy_o[w_winner] = 1'b1;
                    w_grant             = 1'b1;
                    w_state_nxt         = w_cache_hit ? c_st_resp : c_st_issue;
                end
            end
            c_st_issue: begin
                div_in_vld_o = 1'b1;
                if (w_owner_flush) begin
                    // An accepted op must be aborted on the following cycle.
                    w_rr_update = 1'b1;
                    w_state_nxt = div_in_rdy_i ? c_st_kill : c_st_idle;
                end else if (div_in_rdy_i) begin
                    w_state_nxt = c_st_busy;
                end
            end
            c_st_busy: begin
                div_out_rdy_o = 1'b1;
                if (w_owner_flush) begin
                    // A result arriving now is simply consumed; no abort needed.
                    div_flush_o = ~div_out_vld_i;
                    w_rr_update = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if (div_out_vld_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_kill: begin
                div_flush_o = 1'b1;
                w_state_nxt = c_st_idle;
            end
            c_st_resp: begin
                resp_vld_o[r_owner] = ~w_owner_flush;
                if (w_owner_flush || resp_rdy_i[r_owner]) begin
                    w_rr_update = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Operand latch, response capture and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr   <= 1'b0;
            r_owner    <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_opcode   <= '0;
            r_id       <= '0;
            r_resp_id  <= '0;
            r_resp_res <= '0;
        end else begin
            if (w_grant) begin
                r_op_a   <= req_op_a_i[w_winner];
                r_op_b   <= req_op_b_i[w_winner];
                r_opcode <= req_opcode_i[w_winner];
                r_id     <= req_id_i[w_winner];
                r_owner  <= w_winner;
`ifdef DIV_ARB_RESULT_CACHE_EN
                if (w_cache_hit) begin
                    r_resp_res <= r_cache_res;
                    r_resp_id  <= req_id_i[w_winner];
                end
`endif
            end
            if (w_capture) begin
                r_resp_res <= div_res_i;
                r_resp_id  <= div_id_i;
            end
            if (w_rr_update) begin
                r_rr_ptr <= ~r_owner;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one serial divider instance between two requester ports, e.g. two execute lanes.
- Selects one pending request by round-robin and latches its operands, opcode and ID.
- Issues the operation to the divider, collects the result and returns it to the owning port.
- Per-port flush kills the owner's in-flight operation, including aborting the divider. The divider is instantiated with STABLE_HANDSHAKE=1.

Parameters:
- WIDTH, 64, operand/result width; passed to the divider.
- ID_W, TRANS_ID_BITS (config_pkg), transaction ID width.
- NR_PORTS, 2, number of requesters; fixed at 2, round-robin pointer is 1 bit.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_vld_i  in  2  request valid per port.
- req_rdy_o  out  2  request accepted per port.
- req_op_a_i  in  2xWIDTH  dividend per port.
- req_op_b_i  in  2xWIDTH  divisor per port.
- req_opcode_i  in  2x2  0 udiv, 1 div, 2 urem, 3 rem.
- req_id_i  in  2xID_W  transaction ID per port.
- flush_i  in  2  kill the port's outstanding operation.
- resp_vld_o  out  2  result valid per port.
- resp_rdy_i  in  2  result taken per port.
- resp_id_o  out  ID_W  ID of the returned result.
- resp_res_o  out  WIDTH  returned result.
- div_op_a_o, div_op_b_o  out  WIDTH  divider operands.
- div_opcode_o  out  2  divider opcode.
- div_id_o  out  ID_W  divider ID.
- div_in_vld_o  out  1  divider input valid.
- div_in_rdy_i  in  1  divider input ready.
- div_flush_o  out  1  divider abort.
- div_out_vld_i  in  1  divider result valid.
- div_out_rdy_o  out  1  divider result ready.
- div_id_i  in  ID_W  divider result ID.
- div_res_i  in  WIDTH  divider result.

Behaviour:
- One clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state:
  - state=IDLE, rr_ptr=0, owner=0.
  - All of req_rdy_o, resp_vld_o, div_in_vld_o, div_flush_o and div_out_rdy_o are 0.
  - resp_id_o/resp_res_o and the operand registers are 0.
- Reset mid-operation does not flush the divider; the divider must share rst_i.
- Grant:
  - Applies only in IDLE. eligible[p] = req_vld_i[p] & ~flush_i[p].
  - If both ports are eligible, the winner is rr_ptr; otherwise the single eligible port wins.
  - req_rdy_o[winner]=1 combinationally in the same cycle; req_rdy_o is 0 in every other state.
  - On grant: latch op_a, op_b, opcode, id and owner; state to ISSUE.
- ISSUE:
  - div_in_vld_o=1, driven from the latched registers.
  - On div_in_rdy_i, go to BUSY.
  - flush_i[owner] with no accept: div_in_vld_o is still asserted this cycle but the transfer is ignored; go to IDLE.
  - flush_i[owner] together with an accept: go to BUSY-kill, i.e. assert div_flush_o for one cycle next cycle, then IDLE.
- BUSY:
  - div_out_rdy_o=1.
  - On div_out_vld_i: capture div_res_i/div_id_i into resp_res_o/resp_id_o; go to RESP.
  - flush_i[owner] with no result this cycle: div_flush_o=1 this cycle; go to IDLE.
  - flush_i[owner] in the same cycle as div_out_vld_i: consume the result, discard it, no div_flush_o; go to IDLE.
- RESP:
  - resp_vld_o[owner]=1, with id/res held stable until resp_rdy_i[owner].
  - On the handshake: rr_ptr = ~owner; go to IDLE.
  - flush_i[owner]: drop resp_vld_o and go to IDLE; rr_ptr is still updated.
- rr_ptr changes only on completion or kill of an op, never on grant alone.
- flush_i of the non-owner port has no effect outside IDLE.
- Latency:
  - Grant at cycle T, ISSUE at T+1.
  - resp_vld_o rises the cycle after the div_out_vld_i handshake.
  - Back-to-back: the next grant happens in the cycle after the resp handshake.
- Only one operation is ever outstanding; there are no queues.

Optional Feature:
- Macro DIV_ARB_RESULT_CACHE_EN.
- Defined:
  - One entry holds {op_a, op_b, opcode, result, valid}. It is written on every non-discarded divider result and cleared on reset.
  - On a grant whose operands and opcode match a valid entry, go IDLE to RESP directly with the cached result and the new request's id; the divider is not touched.
- Undefined: no entry; every operation goes through the divider.

Test Plan:
- Port0 issues udiv 100/7, id 3, alone -> div_in_vld_o one accept; resp_vld_o[0] with res 14, id 3; resp_vld_o[1] stays 0.
- Both ports valid at reset: port0 rem -7/2, port1 div 20/-3 -> port0 granted first with res 0xFFFF_FFFF_FFFF_FFFF (-1); port1 granted next with res -6.
- Port1 div 50/5 in BUSY, flush_i[1] held 1 cycle -> div_flush_o pulses 1 cycle; no resp_vld_o; next port0 udiv 9/3 returns 3.
- div_out_vld_i and flush_i[owner] in the same cycle -> result consumed, no resp_vld_o, div_flush_o=0, state IDLE.
- resp_rdy_i[0] low for 5 cycles in RESP -> resp_vld_o[0], id and res stable; port1 request is not granted until the handshake.
- With DIV_ARB_RESULT_CACHE_EN: udiv 81/9 twice, id 1 then id 2 -> second response is 9, id 2, returned 1 cycle after grant, with no div_in_vld_o.
